// File: rtl/riscv_pkg.sv
// Shared definitions for the RISCV core retire/write-back path.
package riscv_pkg;

  // Write-back kind encodings carried alongside each retiring instruction.
  typedef enum logic [1:0] {
    KIND_RW    = 2'd0,
    KIND_BR    = 2'd1,
    KIND_ST    = 2'd2,
    KIND_OTHER = 2'd3
  } wb_kind_e;

  // Halt pair: addi x1,x0,12 followed by jalr x0,0(x1).
  localparam logic [31:0] HALT_INST0_DEF = 32'h00c00093;
  localparam logic [31:0] HALT_INST1_DEF = 32'h00008067;

  // Trace record = {pc[11:0], observed result[31:0]}.
  localparam int unsigned TRACE_W = 44;

  // Halt-pair detector states.
  typedef enum logic {
    HALT_IDLE = 1'b0,
    HALT_SAW0 = 1'b1
  } halt_state_e;

endpackage

// File: rtl/retire_trace_fifo.sv
// Synchronous FIFO for retired-instruction trace records.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module retire_trace_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push into a full FIFO still succeeds when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head is presented directly from storage; forced to zero when empty.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO so no stale record is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Record storage write.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/riscv_retire_reporter.sv
// Retire reporter: instruction counter, observed-result port, sticky halt
// detection and a trace FIFO with drop accounting for a debug reader.
module riscv_retire_reporter
  import riscv_pkg::*;
#(
  parameter int unsigned  TRACE_DEPTH = 4,
  parameter logic [31:0]  HALT_INST0  = HALT_INST0_DEF,
  parameter logic [31:0]  HALT_INST1  = HALT_INST1_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WB_VALID,
  input  logic [31:0]        WB_INST,
  input  logic [11:0]        WB_PC,
  input  logic [1:0]         WB_KIND,
  input  logic [31:0]        WB_RD_DATA,
  input  logic               WB_BR_TAKEN,
  input  logic [11:0]        WB_ST_ADDR,
  output logic [31:0]        NUM_INST,
  output logic [31:0]        OUTPUT_PORT,
  output logic               HALT,
  output logic               TR_VALID,
  input  logic               TR_READY,
  output logic [TRACE_W-1:0] TR_DATA,
  output logic [7:0]         TR_DROPS
);

  logic [31:0]        r_num_inst;
  logic [31:0]        r_out;
  logic               r_halt;
  logic [7:0]         r_drops;
  halt_state_e        r_hstate;
  halt_state_e        w_hstate_nxt;
  logic               w_halt_set;
  logic               w_accept;
  logic [31:0]        w_new_out;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [TRACE_W-1:0] w_rec;

  assign w_accept = WB_VALID && !r_halt;

  // Result observed for this retire, chosen by write-back kind.
  always_comb begin
    w_new_out = r_out;
    case (wb_kind_e'(WB_KIND))
      KIND_RW: w_new_out = WB_RD_DATA;
      KIND_BR: w_new_out = {31'b0, WB_BR_TAKEN};
      KIND_ST: w_new_out = {20'b0, WB_ST_ADDR};
      default: w_new_out = r_out;
    endcase
  end

  // Counter, result port and sticky halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_num_inst <= '0;
      r_out      <= '0;
      r_halt     <= 1'b0;
    end else if (w_accept) begin
      r_num_inst <= r_num_inst + 32'd1;
      r_out      <= w_new_out;
      if (w_halt_set) r_halt <= 1'b1;
    end
  end

  // Halt-pair detector state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_hstate <= HALT_IDLE;
    else     r_hstate <= w_hstate_nxt;
  end

  // Halt-pair next state; only accepted retires advance it, so bubbles keep the pair.
  always_comb begin
    w_hstate_nxt = r_hstate;
    w_halt_set   = 1'b0;
    if (w_accept) begin
      case (r_hstate)
        HALT_IDLE: begin
          if (WB_INST == HALT_INST0) w_hstate_nxt = HALT_SAW0;
        end
        HALT_SAW0: begin
          if (WB_INST == HALT_INST1) begin
            w_halt_set   = 1'b1;
            w_hstate_nxt = HALT_IDLE;
          end else if (WB_INST == HALT_INST0) begin
            w_hstate_nxt = HALT_SAW0;
          end else begin
            w_hstate_nxt = HALT_IDLE;
          end
        end
        default: w_hstate_nxt = HALT_IDLE;
      endcase
    end
  end

  assign w_push = w_accept && (wb_kind_e'(WB_KIND) != KIND_OTHER);
  assign w_pop  = TR_VALID && TR_READY;
  assign w_drop = w_push && w_full && !w_pop;
  assign w_rec  = {WB_PC, w_new_out};

  retire_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (TR_DATA),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drops <= '0;
    end else if (w_drop && (r_drops != 8'hff)) begin
      r_drops <= r_drops + 8'd1;
    end
  end

  assign NUM_INST    = r_num_inst;
  assign OUTPUT_PORT = r_out;
  assign HALT        = r_halt;
  assign TR_VALID    = !w_empty;
  assign TR_DROPS    = r_drops;

endmodule

// File: tb/tb_riscv_retire_reporter.sv
module tb_riscv_retire_reporter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WB_VALID = 1'b0;
  logic [31:0] WB_INST = '0;
  logic [11:0] WB_PC = '0;
  logic [1:0]  WB_KIND = '0;
  logic [31:0] WB_RD_DATA = '0;
  logic        WB_BR_TAKEN = 1'b0;
  logic [11:0] WB_ST_ADDR = '0;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;
  logic        TR_VALID;
  logic        TR_READY = 1'b0;
  logic [43:0] TR_DATA;
  logic [7:0]  TR_DROPS;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] H0  = 32'h00c00093;
  localparam logic [31:0] H1  = 32'h00008067;
  localparam logic [31:0] NOP = 32'h00000013;

  riscv_retire_reporter #(
    .TRACE_DEPTH (4),
    .HALT_INST0  (32'h00c00093),
    .HALT_INST1  (32'h00008067)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WB_VALID    (WB_VALID),
    .WB_INST     (WB_INST),
    .WB_PC       (WB_PC),
    .WB_KIND     (WB_KIND),
    .WB_RD_DATA  (WB_RD_DATA),
    .WB_BR_TAKEN (WB_BR_TAKEN),
    .WB_ST_ADDR  (WB_ST_ADDR),
    .NUM_INST    (NUM_INST),
    .OUTPUT_PORT (OUTPUT_PORT),
    .HALT        (HALT),
    .TR_VALID    (TR_VALID),
    .TR_READY    (TR_READY),
    .TR_DATA     (TR_DATA),
    .TR_DROPS    (TR_DROPS)
  );

  always #5 CLK = ~CLK;

  // Drive one retire for one edge; inputs change 1 time unit after posedge.
  task automatic retire(input logic [31:0] inst, input logic [11:0] pc,
                        input logic [1:0] kind, input logic [31:0] rd,
                        input logic taken, input logic [11:0] st);
    WB_VALID = 1'b1; WB_INST = inst; WB_PC = pc; WB_KIND = kind;
    WB_RD_DATA = rd; WB_BR_TAKEN = taken; WB_ST_ADDR = st;
    @(posedge CLK); #1;
    WB_VALID = 1'b0; WB_INST = 32'hdeadbeef; WB_RD_DATA = 32'hbad0bad0;
  endtask

  task automatic bubble();
    WB_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (NUM_INST !== 32'd0) begin bad++; $display("FAIL reset_num got=%h exp=0", NUM_INST); end
    total++; if (OUTPUT_PORT !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", OUTPUT_PORT); end
    total++; if (HALT !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", HALT); end
    total++; if (TR_VALID !== 1'b0 || TR_DATA !== 44'd0 || TR_DROPS !== 8'd0) begin
      bad++; $display("FAIL reset_trace got v=%b d=%h dr=%0d exp 0/0/0", TR_VALID, TR_DATA, TR_DROPS);
    end
  endtask

  task automatic test_regwrite();
    logic [43:0] exp_rec [3];
    exp_rec[0] = {12'h100, 32'h00000eec};
    exp_rec[1] = {12'h104, 32'h00000000};
    exp_rec[2] = {12'h108, 32'h00000001};
    TR_READY = 1'b0;
    retire(NOP, 12'h100, 2'd0, 32'h00000eec, 1'b0, 12'h0);
    total++; if (NUM_INST !== 32'd1 || OUTPUT_PORT !== 32'h00000eec) begin
      bad++; $display("FAIL rw1 got num=%0d out=%h exp num=1 out=eec", NUM_INST, OUTPUT_PORT);
    end
    retire(NOP, 12'h104, 2'd0, 32'h0, 1'b0, 12'h0);
    total++; if (NUM_INST !== 32'd2 || OUTPUT_PORT !== 32'h0) begin
      bad++; $display("FAIL rw2 got num=%0d out=%h exp num=2 out=0", NUM_INST, OUTPUT_PORT);
    end
    retire(NOP, 12'h108, 2'd0, 32'h1, 1'b0, 12'h0);
    total++; if (NUM_INST !== 32'd3 || OUTPUT_PORT !== 32'h1) begin
      bad++; $display("FAIL rw3 got num=%0d out=%h exp num=3 out=1", NUM_INST, OUTPUT_PORT);
    end
    TR_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (TR_VALID !== 1'b1 || TR_DATA !== exp_rec[i]) begin
        bad++; $display("FAIL rw_drain%0d got v=%b d=%h exp v=1 d=%h", i, TR_VALID, TR_DATA, exp_rec[i]);
      end
      @(posedge CLK); #1;
    end
    TR_READY = 1'b0;
    total++; if (TR_VALID !== 1'b0) begin bad++; $display("FAIL rw_empty got v=%b exp 0", TR_VALID); end
  endtask

  task automatic test_kinds();
    retire(32'h00208463, 12'h10c, 2'd1, 32'h12345678, 1'b1, 12'h0);
    total++; if (NUM_INST !== 32'd4 || OUTPUT_PORT !== 32'h1) begin
      bad++; $display("FAIL br got num=%0d out=%h exp num=4 out=1", NUM_INST, OUTPUT_PORT);
    end
    retire(32'h00112023, 12'h110, 2'd2, 32'h12345678, 1'b0, 12'hf00);
    total++; if (NUM_INST !== 32'd5 || OUTPUT_PORT !== 32'h00000f00) begin
      bad++; $display("FAIL st got num=%0d out=%h exp num=5 out=f00", NUM_INST, OUTPUT_PORT);
    end
    retire(32'h0000000f, 12'h114, 2'd3, 32'h12345678, 1'b1, 12'h0ab);
    total++; if (NUM_INST !== 32'd6 || OUTPUT_PORT !== 32'h00000f00) begin
      bad++; $display("FAIL other got num=%0d out=%h exp num=6 out=f00", NUM_INST, OUTPUT_PORT);
    end
    // Only the branch and store records are present; kind 3 was not traced.
    TR_READY = 1'b1;
    total++; if (TR_VALID !== 1'b1 || TR_DATA !== {12'h10c, 32'h1}) begin
      bad++; $display("FAIL br_rec got v=%b d=%h exp v=1 d=%h", TR_VALID, TR_DATA, {12'h10c, 32'h1});
    end
    @(posedge CLK); #1;
    total++; if (TR_VALID !== 1'b1 || TR_DATA !== {12'h110, 32'hf00}) begin
      bad++; $display("FAIL st_rec got v=%b d=%h exp v=1 d=%h", TR_VALID, TR_DATA, {12'h110, 32'hf00});
    end
    @(posedge CLK); #1;
    total++; if (TR_VALID !== 1'b0) begin bad++; $display("FAIL other_not_traced got v=%b exp 0", TR_VALID); end
    TR_READY = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [43:0] exp_rec [4];
    TR_READY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retire(NOP, 12'h200 + 12'(4 * i), 2'd0, 32'h000000a0 + 32'(i), 1'b0, 12'h0);
      total++; if (TR_VALID !== 1'b1 || TR_DATA !== {12'h200, 32'h000000a0}) begin
        bad++; $display("FAIL full_head%0d got v=%b d=%h exp v=1 d=%h", i, TR_VALID, TR_DATA, {12'h200, 32'ha0});
      end
    end
    total++; if (TR_DROPS !== 8'd2 || NUM_INST !== 32'd12) begin
      bad++; $display("FAIL drops got dr=%0d num=%0d exp dr=2 num=12", TR_DROPS, NUM_INST);
    end
    // Push and pop together while full: no drop, head advances.
    TR_READY = 1'b1;
    retire(NOP, 12'h300, 2'd0, 32'h000000b0, 1'b0, 12'h0);
    total++; if (TR_DROPS !== 8'd2 || NUM_INST !== 32'd13) begin
      bad++; $display("FAIL pushpop_full got dr=%0d num=%0d exp dr=2 num=13", TR_DROPS, NUM_INST);
    end
    exp_rec[0] = {12'h204, 32'ha1};
    exp_rec[1] = {12'h208, 32'ha2};
    exp_rec[2] = {12'h20c, 32'ha3};
    exp_rec[3] = {12'h300, 32'hb0};
    for (int i = 0; i < 4; i++) begin
      total++; if (TR_VALID !== 1'b1 || TR_DATA !== exp_rec[i]) begin
        bad++; $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, TR_VALID, TR_DATA, exp_rec[i]);
      end
      @(posedge CLK); #1;
    end
    total++; if (TR_VALID !== 1'b0) begin bad++; $display("FAIL full_empty got v=%b exp 0", TR_VALID); end
  endtask

  task automatic test_halt_broken();
    TR_READY = 1'b1;
    retire(H0, 12'h400, 2'd0, 32'd12, 1'b0, 12'h0);
    retire(NOP, 12'h404, 2'd0, 32'd0, 1'b0, 12'h0);
    retire(H1, 12'h408, 2'd3, 32'd0, 1'b0, 12'h0);
    total++; if (HALT !== 1'b0 || NUM_INST !== 32'd16) begin
      bad++; $display("FAIL halt_broken got halt=%b num=%0d exp halt=0 num=16", HALT, NUM_INST);
    end
  endtask

  task automatic test_halt_bubbles();
    retire(H0, 12'h40c, 2'd0, 32'd12, 1'b0, 12'h0);
    bubble();
    bubble();
    total++; if (HALT !== 1'b0 || NUM_INST !== 32'd17) begin
      bad++; $display("FAIL halt_pre got halt=%b num=%0d exp halt=0 num=17", HALT, NUM_INST);
    end
    retire(H1, 12'h410, 2'd3, 32'd0, 1'b0, 12'h0);
    total++; if (HALT !== 1'b1 || NUM_INST !== 32'd18 || OUTPUT_PORT !== 32'd12) begin
      bad++; $display("FAIL halt_set got halt=%b num=%0d out=%h exp halt=1 num=18 out=c", HALT, NUM_INST, OUTPUT_PORT);
    end
    retire(NOP, 12'h414, 2'd0, 32'h55, 1'b0, 12'h0);
    retire(NOP, 12'h418, 2'd2, 32'h0, 1'b0, 12'h777);
    total++; if (HALT !== 1'b1 || NUM_INST !== 32'd18 || OUTPUT_PORT !== 32'd12 || TR_VALID !== 1'b0) begin
      bad++; $display("FAIL halt_frozen got halt=%b num=%0d out=%h v=%b exp 1/18/c/0", HALT, NUM_INST, OUTPUT_PORT, TR_VALID);
    end
  endtask

  task automatic test_halt_repeat();
    do_reset();
    TR_READY = 1'b1;
    retire(H0, 12'h000, 2'd0, 32'd12, 1'b0, 12'h0);
    retire(H0, 12'h004, 2'd0, 32'd12, 1'b0, 12'h0);
    total++; if (HALT !== 1'b0) begin bad++; $display("FAIL halt_rep_pre got halt=%b exp 0", HALT); end
    retire(H1, 12'h008, 2'd3, 32'd0, 1'b0, 12'h0);
    total++; if (HALT !== 1'b1 || NUM_INST !== 32'd3) begin
      bad++; $display("FAIL halt_rep got halt=%b num=%0d exp halt=1 num=3", HALT, NUM_INST);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    TR_READY = 1'b0;
    retire(NOP, 12'h020, 2'd0, 32'h77, 1'b0, 12'h0);
    retire(H0, 12'h024, 2'd0, 32'd12, 1'b0, 12'h0);
    total++; if (TR_VALID !== 1'b1 || NUM_INST !== 32'd2) begin
      bad++; $display("FAIL mid_pre got v=%b num=%0d exp v=1 num=2", TR_VALID, NUM_INST);
    end
    #2 RST = 1'b1;
    #1;
    total++; if (NUM_INST !== 32'd0 || OUTPUT_PORT !== 32'd0 || HALT !== 1'b0 ||
                 TR_VALID !== 1'b0 || TR_DATA !== 44'd0 || TR_DROPS !== 8'd0) begin
      bad++; $display("FAIL mid_reset got num=%0d out=%h h=%b v=%b d=%h dr=%0d exp all 0",
                      NUM_INST, OUTPUT_PORT, HALT, TR_VALID, TR_DATA, TR_DROPS);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    retire(H1, 12'h028, 2'd3, 32'd0, 1'b0, 12'h0);
    total++; if (HALT !== 1'b0 || NUM_INST !== 32'd1 || OUTPUT_PORT !== 32'd0) begin
      bad++; $display("FAIL mid_after got halt=%b num=%0d out=%h exp halt=0 num=1 out=0", HALT, NUM_INST, OUTPUT_PORT);
    end
  endtask

  initial begin
    test_reset();
    test_regwrite();
    test_kinds();
    test_fifo_full();
    test_halt_broken();
    test_halt_bubbles();
    test_halt_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
